// File: rtl/tx_frame_pkg.sv
// Shared types and frame geometry helpers for the TX frame serializer.
package tx_frame_pkg;

  // Serializer FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Bit positions inside the status nibble.
  localparam int STAT_PEND  = 0;
  localparam int STAT_CARRY = 1;

  // Number of data nibbles needed to carry {carry, result}.
  function automatic int ndata(input int res_w, input int nib_w);
    return (res_w + 1 + nib_w - 1) / nib_w;
  endfunction

  // Total nibbles per frame: data nibbles, status nibble, optional checksum.
  function automatic int frame_len(input int res_w, input int nib_w, input int chk_en);
    return ndata(res_w, nib_w) + 1 + chk_en;
  endfunction

endpackage

// File: rtl/tx_frame_fifo.sv
// Small synchronous FIFO holding {carry, result} words ahead of the serializer.
// Head word is presented combinationally on dout whenever the FIFO is non-empty.
module tx_frame_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_frame_serializer.sv
// TX stage: buffers ALU results and shifts each one out on the nibble-wide
// MISO bus as a frame of data nibbles (LS first), a status nibble and an
// optional XOR checksum nibble. Dropping spi_r mid-frame aborts the frame and
// leaves the word at the FIFO head so it is replayed from nibble 0.
//
// Handshake: a result is accepted on every clk edge where res_valid and
// res_ready are both high; res_ready depends only on FIFO occupancy, and the
// producer must hold res_data/carry_in stable while res_valid is high and
// res_ready is low.
module tx_frame_serializer
  import tx_frame_pkg::*;
#(
  parameter int RES_W      = 10,
  parameter int NIB_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CHK_EN     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_clk,
  input  logic                          spi_r,
  input  logic [RES_W-1:0]              res_data,
  input  logic                          carry_in,
  input  logic                          res_valid,
  output logic                          res_ready,
  output logic [NIB_W-1:0]              miso,
  output logic                          carry_out,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          tx_abort,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NDATA     = ndata(RES_W, NIB_W);
  localparam int FRAME_LEN = frame_len(RES_W, NIB_W, CHK_EN);
  localparam int DATA_W    = NDATA * NIB_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // FIFO interface
  logic [RES_W:0]     fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  // FSM and frame datapath
  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               latch;
  logic               done_d;
  logic               abort_d;
  logic               done_q;
  logic               abort_q;
  logic [DATA_W-1:0]  frame_q;
  logic               pend_q;
  logic               carry_q;
  logic               spi_clk_prev;
  logic               fall;
  logic [NIB_W-1:0]   stat_nib;
  logic [NIB_W-1:0]   chk_nib;
  logic [NIB_W-1:0]   nib [FRAME_LEN];
  logic [NIB_W-1:0]   nib_sel;

  assign res_ready = !fifo_full;
  assign fifo_push = res_valid && res_ready;
  assign fall      = ~spi_clk & spi_clk_prev;

  tx_frame_fifo #(
    .W     (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({carry_in, res_data}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state and nibble index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: start on a non-empty FIFO, advance on SPI falling edges, abort on spi_r low.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    latch    = 1'b0;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && spi_r) begin
          state_d = SEND;
          idx_d   = '0;
          latch   = 1'b1;
        end
      end
      SEND: begin
        if (!spi_r) begin
          state_d = IDLE;
          idx_d   = '0;
          abort_d = 1'b1;
        end else if (fall) begin
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            idx_d    = '0;
            fifo_pop = 1'b1;
            done_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Frame register, status bits, event pulses and SPI clock history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q      <= '0;
      pend_q       <= 1'b0;
      carry_q      <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      spi_clk_prev <= 1'b0;
    end else begin
      spi_clk_prev <= spi_clk;
      done_q       <= done_d;
      abort_q      <= abort_d;
      if (latch) begin
        frame_q <= DATA_W'(fifo_head);
        pend_q  <= (fifo_count > CNT_W'(1));
        carry_q <= fifo_head[RES_W];
      end
    end
  end

  // Assemble the frame nibbles: data, status, then the running XOR checksum.
  always_comb begin
    stat_nib             = '0;
    stat_nib[STAT_PEND]  = pend_q;
    stat_nib[STAT_CARRY] = carry_q;
    chk_nib              = stat_nib;
    for (int k = 0; k < NDATA; k++) begin
      nib[k]  = frame_q[k*NIB_W +: NIB_W];
      chk_nib = chk_nib ^ frame_q[k*NIB_W +: NIB_W];
    end
    nib[NDATA] = stat_nib;
    for (int k = NDATA + 1; k < FRAME_LEN; k++) begin
      nib[k] = chk_nib;
    end
  end

  // Select the nibble at the current index.
  always_comb begin
    nib_sel = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_sel = nib[k];
      end
    end
  end

  assign miso      = (state_q == SEND && spi_r) ? nib_sel : '0;
  assign tx_busy   = (state_q == SEND);
  assign tx_done   = done_q;
  assign tx_abort  = abort_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: default instance (RES_W=10, NIB_W=4,
// CHK_EN=1) and a wide-nibble instance without checksum (RES_W=16, NIB_W=8).
module tb_tx_frame_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared SPI inputs
  logic spi_clk;
  logic spi_r;

  // instance A (defaults)
  logic [9:0] res_data;
  logic       carry_in;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] miso;
  logic       carry_out;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_abort;
  logic [1:0] fifo_count;

  // instance B (16-bit result, byte nibbles, no checksum)
  logic [15:0] b_data;
  logic        b_carry;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_miso;
  logic        b_carry_out;
  logic        b_busy;
  logic        b_done;
  logic        b_abort;
  logic [1:0]  b_count;

  tx_frame_serializer dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_r      (spi_r),
    .res_data   (res_data),
    .carry_in   (carry_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .miso       (miso),
    .carry_out  (carry_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .fifo_count (fifo_count)
  );

  tx_frame_serializer #(
    .RES_W (16), .NIB_W (8), .FIFO_DEPTH (2), .CHK_EN (0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_r      (spi_r),
    .res_data   (b_data),
    .carry_in   (b_carry),
    .res_valid  (b_valid),
    .res_ready  (b_ready),
    .miso       (b_miso),
    .carry_out  (b_carry_out),
    .tx_busy    (b_busy),
    .tx_done    (b_done),
    .tx_abort   (b_abort),
    .fifo_count (b_count)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int done_cnt   = 0;
  int abort_cnt  = 0;
  int b_done_cnt = 0;
  logic busy_at_done = 1'b0;

  typedef struct {
    logic [9:0]  res;
    logic        carry;
    logic [19:0] nibs;  // first nibble in the most significant position
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_done) begin
        done_cnt++;
        busy_at_done = busy_at_done | tx_busy;
      end
      if (tx_abort) abort_cnt++;
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [9:0] d, input logic c);
    res_data  = d;
    carry_in  = c;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] d, input logic c);
    b_data  = d;
    b_carry = c;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
  endtask

  // One SPI period: high for two clk cycles (sample here), low for two (falling edge seen).
  task automatic spi_period(output logic [3:0] ma, output logic [7:0] mb);
    spi_clk = 1'b1;
    tick();
    tick();
    @(negedge clk);
    ma = miso;
    mb = b_miso;
    @(posedge clk);
    #1;
    spi_clk = 1'b0;
    tick();
    tick();
  endtask

  task automatic expect_frame_a(input logic [19:0] nibs);
    for (int k = 0; k < 5; k++) exp_q.push_back({4'h0, nibs[19-4*k -: 4]});
  endtask

  // Clock n nibbles out of instance A and compare against the expected queue.
  task automatic recv_a(input string name, input int n);
    logic [3:0] ma;
    logic [7:0] mb;
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      spi_period(ma, mb);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("%s nib%0d", name, k), {28'h0, ma}, {24'h0, e});
    end
  endtask

  task automatic recv_b(input string name, input int n);
    logic [3:0] ma;
    logic [7:0] mb;
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      spi_period(ma, mb);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("%s nib%0d", name, k), {24'h0, mb}, {24'h0, e});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int a0;
    logic [3:0] ma;
    logic [7:0] mb;

    vecs[0] = '{res: 10'h2A5, carry: 1'b1, nibs: 20'h5A62B};
    vecs[1] = '{res: 10'h3FF, carry: 1'b1, nibs: 20'hFF725};
    vecs[2] = '{res: 10'h123, carry: 1'b0, nibs: 20'h32100};
    vecs[3] = '{res: 10'h15A, carry: 1'b0, nibs: 20'hA510E};

    rst_n = 1'b0; spi_clk = 1'b0; spi_r = 1'b0;
    res_data = '0; carry_in = 1'b0; res_valid = 1'b0;
    b_data = '0; b_carry = 1'b0; b_valid = 1'b0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    check("rst miso", miso, 0);
    check("rst busy", tx_busy, 0);
    check("rst count", fifo_count, 0);
    check("rst ready", res_ready, 1);
    check("rst done", tx_done, 0);
    check("rst abort", tx_abort, 0);
    check("rst carry", carry_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // table: single frames with spi_r held high
    spi_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      push_a(vecs[i].res, vecs[i].carry);
      check($sformatf("v%0d count after push", i), fifo_count, 1);
      expect_frame_a(vecs[i].nibs);
      recv_a($sformatf("v%0d", i), 1);
      check($sformatf("v%0d busy", i), tx_busy, 1);
      check($sformatf("v%0d carry_out", i), carry_out, vecs[i].carry);
      recv_a($sformatf("v%0d", i), 4);
      @(negedge clk);
      check($sformatf("v%0d done pulses", i), done_cnt - d0, 1);
      check($sformatf("v%0d count after frame", i), fifo_count, 0);
      check($sformatf("v%0d idle busy", i), tx_busy, 0);
      check($sformatf("v%0d idle miso", i), miso, 0);
      check($sformatf("v%0d carry hold", i), carry_out, vecs[i].carry);
      @(posedge clk); #1;
    end

    // fill with spi_r low, hold off a third result, then drain back-to-back
    spi_r = 1'b0;
    push_a(10'h2A5, 1'b1);
    push_a(10'h000, 1'b0);
    @(negedge clk);
    check("full ready", res_ready, 0);
    check("full count", fifo_count, 2);
    @(posedge clk); #1;
    res_data = 10'h3FF; carry_in = 1'b1; res_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("holdoff count", fifo_count, 2);
    check("holdoff ready", res_ready, 0);
    check("holdoff idle", tx_busy, 0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    d0 = done_cnt;
    busy_at_done = 1'b0;
    spi_r = 1'b1;
    expect_frame_a(20'h5A63A);
    expect_frame_a(20'h00000);
    recv_a("b2b", 10);
    @(negedge clk);
    check("b2b done pulses", done_cnt - d0, 2);
    check("b2b idle gap", busy_at_done, 0);
    check("b2b count", fifo_count, 0);
    @(posedge clk); #1;

    // abort after two nibbles, then replay
    d0 = done_cnt;
    a0 = abort_cnt;
    push_a(10'h2A5, 1'b1);
    exp_q.push_back(8'h5);
    exp_q.push_back(8'hA);
    recv_a("pre-abort", 2);
    spi_r = 1'b0;
    tick();
    @(negedge clk);
    check("abort busy", tx_busy, 0);
    check("abort count", fifo_count, 1);
    check("abort miso", miso, 0);
    check("abort pulse", tx_abort, 1);
    @(posedge clk); #1;
    tick();
    check("abort pulses", abort_cnt - a0, 1);
    check("abort no done", done_cnt - d0, 0);
    spi_r = 1'b1;
    expect_frame_a(20'h5A62B);
    recv_a("replay", 5);
    @(negedge clk);
    check("replay done", done_cnt - d0, 1);
    check("replay count", fifo_count, 0);
    @(posedge clk); #1;

    // wide-nibble instance without checksum
    d0 = b_done_cnt;
    push_b(16'hBEEF, 1'b0);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    recv_b("wide0", 4);
    push_b(16'hBEEF, 1'b1);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    recv_b("wide1", 4);
    @(negedge clk);
    check("wide done pulses", b_done_cnt - d0, 2);
    check("wide count", b_count, 0);
    check("wide carry", b_carry_out, 1);
    check("wide busy", b_busy, 0);
    @(posedge clk); #1;

    // asynchronous reset during the third nibble
    spi_r = 1'b0;
    push_a(10'h2A5, 1'b1);
    push_a(10'h000, 1'b0);
    spi_r = 1'b1;
    exp_q.push_back(8'h5);
    exp_q.push_back(8'hA);
    recv_a("pre-reset", 2);
    spi_clk = 1'b1;
    tick();
    @(negedge clk);
    check("pre-reset nib2", miso, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst miso", miso, 0);
    check("async rst busy", tx_busy, 0);
    check("async rst count", fifo_count, 0);
    check("async rst ready", res_ready, 1);
    check("async rst carry", carry_out, 0);
    spi_clk = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("post-reset busy", tx_busy, 0);
    check("post-reset count", fifo_count, 0);
    check("scoreboard empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_serializer.md
Name: tx_frame_serializer

Overview:
- Parametrised successor TX stage. Sits between the ALU result handshake and the nibble-wide SPI MISO bus.
- Buffers up to FIFO_DEPTH {carry, result} words.
- Serialises each word as one frame, least-significant nibble first, followed by a status nibble and an optional XOR checksum nibble.
- Supports abort/replay when spi_r drops mid-frame.

Parameters:
- RES_W, 10: ALU result width (1..32).
- NIB_W, 4: MISO nibble width (4..8).
- FIFO_DEPTH, 2: result buffer entries (power of 2, >=2).
- CHK_EN, 1: 1 appends a checksum nibble; 0 omits it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- spi_clk  in  1  SPI clock, already synchronous to clk; sampled directly
- spi_r  in  1  SPI read enable
- res_data  in  RES_W  ALU result
- carry_in  in  1  ALU carry, qualified with res_valid
- res_valid  in  1  result valid
- res_ready  out  1  buffer can accept a result
- miso  out  NIB_W  MISO data
- carry_out  out  1  carry of the frame in flight
- tx_busy  out  1  frame in progress (state SEND)
- tx_done  out  1  1-cycle pulse: frame completed and popped
- tx_abort  out  1  1-cycle pulse: frame aborted, kept for replay
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset is asynchronous, active-low. Every output and register resets to 0, except res_ready, which resets to 1. State = IDLE, FIFO empty, spi_clk_prev=0.
- Derived constants:
  - NDATA = ceil((RES_W+1)/NIB_W).
  - FRAME_LEN = NDATA+1+CHK_EN. Defaults give 5.
- Frame word W = zero-extend({carry_in, res_data}) to NDATA*NIB_W bits.
  - Data nibble k = W[k*NIB_W +: NIB_W].
  - Status nibble: bit0 = more entries pending behind this frame (fifo_count>1 at latch), bit1 = carry, all other bits 0.
  - Checksum nibble = XOR of all preceding nibbles in the frame.
- Push:
  - res_ready = (fifo_count != FIFO_DEPTH); combinational from count only, no full-bypass.
  - Write occurs on res_valid && res_ready; fifo_count increments the next cycle.
- Edge detect: spi_clk_prev <= spi_clk; fall = ~spi_clk & spi_clk_prev.
- FSM transitions:
  - IDLE -> SEND when fifo_count!=0 && spi_r. On that edge, latch the FIFO head into the frame register, latch the status bits, set idx=0 and latch carry_out.
  - SEND and spi_r low -> IDLE. Pulse tx_abort, idx=0, no pop. The same head is replayed from nibble 0 on the next start, with pending recomputed.
  - SEND and fall && spi_r:
    - If idx==FRAME_LEN-1: pop head, pulse tx_done, -> IDLE.
    - Otherwise idx++.
- Output rules:
  - miso = nibble[idx] while SEND && spi_r; otherwise 0.
  - tx_busy = (state==SEND).
  - carry_out holds its last latched value in IDLE.
- Latency: push into an empty FIFO at edge N with spi_r high gives SEND at edge N+1, with nibble 0 on miso after edge N+1.
- Push while SEND is allowed. The frame register isolates the in-flight frame, so a push never corrupts it.
- Push and pop in the same cycle: count is unchanged.
- Pop is never issued when empty.
- Back-to-back frames: after tx_done, IDLE lasts at least 1 cycle before the next SEND.
- Reset mid-frame: immediate return to reset values; FIFO contents are discarded.

Decomposition:
- Package tx_frame_pkg holds:
  - state enum {IDLE, SEND}
  - STAT_PEND=0 and STAT_CARRY=1 bit indices
  - function frame_len(RES_W, NIB_W, CHK_EN)
- Sub-module tx_frame_fifo: parametrised synchronous FIFO (width RES_W+1, depth FIFO_DEPTH) with push/pop/count/full/empty, async active-low reset.

Test Plan:
- Defaults, single push res=10'h2A5 carry=1, spi_r=1, 5 spi_clk periods -> miso sequence 5,A,6,2,B; carry_out=1; one tx_done after the 5th falling edge; fifo_count 1 then 0.
- Two back-to-back pushes (2A5/1 then 000/0) -> frame 1 is 5,A,6,3,A (pending=1). Frame 2 is 0,0,0,0,0. Two tx_done pulses, each frame separated by at least 1 IDLE cycle.
- spi_r held 0, three pushes -> res_ready=0 after the 2nd push; fifo_count=2; the 3rd result is held off by the producer.
- Abort: drop spi_r after 2 nibbles of 2A5/1 -> tx_abort pulse, fifo_count stays 1. Re-raising spi_r replays 5,A,6,2,B.
- CHK_EN=0, RES_W=16, NIB_W=8, res=16'hBEEF carry=0 -> frame EF,BE,00,00 (4 nibbles).
- rst_n low during the 3rd nibble -> miso=0, tx_busy=0, fifo_count=0, res_ready=1 immediately, without waiting for a clk edge.
